// File: rtl/gf16_divider_seq.sv
// Sequential GF(2^4) divider, Q = A * B^-1 mod x^4+x+1, with B^-1 = B^14 from square-and-multiply.
// Optional result self-check enabled by defining GF16_DIV_SELFCHECK_EN.
module gf16_divider_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] Q,
  output logic       div_by_zero,
  output logic       chk_err
);

  localparam logic [4:0] POLY      = 5'b10011;
  localparam int         ITER      = 3;
  localparam logic [1:0] LAST_ITER = 2'(ITER - 1);

  // Residues of x^4, x^5, x^6 modulo POLY
  localparam logic [3:0] RED4 = POLY[3:0];
  localparam logic [3:0] RED5 = {POLY[2:0], 1'b0};
  localparam logic [3:0] RED6 = {POLY[1:0], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL, S_DONE} state_t;

  function automatic logic [3:0] gf_reduce(input logic [6:0] p);
    logic [3:0] r;
    r = p[3:0];
    if (p[4]) r = r ^ RED4;
    if (p[5]) r = r ^ RED5;
    if (p[6]) r = r ^ RED6;
    return r;
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    return gf_reduce(p);
  endfunction

  function automatic logic [3:0] gf_sq(input logic [3:0] a);
    return gf_mul(a, a);
  endfunction

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] sq_q, sq_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] a_reg_q, a_reg_d;
  logic       zflag_q, zflag_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] q_q, q_d;
  logic       dbz_q, dbz_d;
`ifdef GF16_DIV_SELFCHECK_EN
  logic [3:0] b_reg_q, b_reg_d;
  logic       chk_q, chk_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sq_d        = sq_q;
    acc_d       = acc_q;
    a_reg_d     = a_reg_q;
    zflag_d     = zflag_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    dbz_d       = dbz_q;
`ifdef GF16_DIV_SELFCHECK_EN
    b_reg_d     = b_reg_q;
    chk_d       = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_reg_d    = A;
          sq_d       = B;
          acc_d      = 4'd1;
          cnt_d      = 2'd0;
          zflag_d    = (B == 4'd0);
          in_ready_d = 1'b0;
          state_d    = S_ITER;
`ifdef GF16_DIV_SELFCHECK_EN
          b_reg_d    = B;
`endif
        end
      end
      S_ITER: begin
        // acc accumulates B^2 * B^4 * B^8 as sq walks through the squares
        sq_d  = gf_sq(sq_q);
        acc_d = gf_mul(acc_q, sq_d);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_ITER) state_d = S_FINAL;
      end
      S_FINAL: begin
        q_d         = zflag_q ? 4'd0 : gf_mul(a_reg_q, acc_q);
        dbz_d       = zflag_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
`ifdef GF16_DIV_SELFCHECK_EN
        chk_d       = !zflag_q && (gf_mul(q_d, b_reg_q) != a_reg_q);
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
`ifdef GF16_DIV_SELFCHECK_EN
          chk_d       = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      sq_q        <= 4'd0;
      acc_q       <= 4'd0;
      a_reg_q     <= 4'd0;
      zflag_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= 4'd0;
      dbz_q       <= 1'b0;
`ifdef GF16_DIV_SELFCHECK_EN
      b_reg_q     <= 4'd0;
      chk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      acc_q       <= acc_d;
      a_reg_q     <= a_reg_d;
      zflag_q     <= zflag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      dbz_q       <= dbz_d;
`ifdef GF16_DIV_SELFCHECK_EN
      b_reg_q     <= b_reg_d;
      chk_q       <= chk_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign Q           = q_q;
  assign div_by_zero = dbz_q;
`ifdef GF16_DIV_SELFCHECK_EN
  assign chk_err     = chk_q;
`else
  assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_gf16_divider_seq.sv
// Scoreboard bench for gf16_divider_seq: directed vectors, backpressure, reset abort, exhaustive sweep.
module tb_gf16_divider_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A, B;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Q;
  logic       div_by_zero;
  logic       chk_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  gf16_divider_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .div_by_zero(div_by_zero), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Shift-and-add model with reduction by x^4 = x + 1 at each doubling
  function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, x;
    r = 4'd0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    end
    return r;
  endfunction

  function automatic logic [3:0] m_inv(input logic [3:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 1; i < 16; i++)
      if (m_mul(b, 4'(i)) == 4'd1) r = 4'(i);
    return r;
  endfunction

  // Monitor: a result handshake completes on the edge after this sample
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("Q", Q, e[3:0]);
          check("div_by_zero", div_by_zero, e[4]);
          check("chk_err", chk_err, 0);
        end
      end
    end
  end

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic ez, input bit verify_qb);
    int n;
    exp_q.push_back({ez, eq});
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; A = a; B = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    wait_out(n);
    check("latency", n, 4);
    if (verify_qb && b != 4'd0) check("qb_eq_a", m_mul(Q, b), a);
    @(posedge clk); #1;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int n, bad;
    rst = 1'b1; in_valid = 1'b0; A = 4'd0; B = 4'd0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_Q", Q, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_chk_err", chk_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'd1,  4'd2, 4'd9,  1'b0, 1'b0);
    run_op(4'd7,  4'd3, 4'd12, 1'b0, 1'b0);
    run_op(4'd15, 4'd9, 4'd13, 1'b0, 1'b0);
    run_op(4'd0,  4'd5, 4'd0,  1'b0, 1'b0);
    run_op(4'd6,  4'd0, 4'd0,  1'b1, 1'b0);

    // Backpressure: result held while a second operand waits
    exp_q.push_back({1'b0, 4'd14});
    in_valid = 1'b1; A = 4'd1; B = 4'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    A = 4'd2; B = 4'd2;
    exp_q.push_back({1'b0, 4'd1});
    wait_out(n);
    check("bp_latency", n, 4);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || Q != 4'd14 || in_ready) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold", bad, 0);
    check("bp_Q_held", Q, 14);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    check("bp_pending_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_out(n);
    check("bp_pending_latency", n, 4);
    @(posedge clk); #1;

    // Reset during ITER with cnt=1; prior Q is 1 so the clear is visible
    in_valid = 1'b1; A = 4'd5; B = 4'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_Q", Q, 0);
    check("arst_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("arst_release_ready", in_ready, 1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("arst_no_output", bad, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b), (b == 0) ? 4'd0 : m_mul(4'(a), m_inv(4'(b))),
               (b == 0), 1'b1);

    @(posedge clk); #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
